// File: rtl/mdu_hilo.sv
// HI/LO multiply/divide unit: 32-iteration shift-add multiply and restoring divide
// on operand magnitudes, plus MTHI/MTLO writes. The core's PC is held while it runs.
module mdu_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            is_div_q;
    logic            neg_q;
    logic            neg_rem_q;
    logic            dz_q;
    logic [W-1:0]    rs_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    mcand_q;
    logic [W:0]      rem_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;

    logic            is_md_c;
    logic            is_signed_c;
    logic            is_div_c;
    logic            rs_neg_c;
    logic            rt_neg_c;
    logic [W-1:0]    rs_mag_c;
    logic [W-1:0]    rt_mag_c;

    logic [W:0]      mul_sum;
    logic [W+1:0]    div_trial;
    logic            div_ge;
    logic [W:0]      rem_d;
    logic [2*W-1:0]  acc_d;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    quot;
    logic [W-1:0]    remf;
    logic [W-1:0]    res_hi;
    logic [W-1:0]    res_lo;

    // Issue decode and operand magnitudes
    always_comb begin
        is_md_c     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        is_signed_c = (op == OP_MULT) || (op == OP_DIV);
        is_div_c    = (op == OP_DIV)  || (op == OP_DIVU);
        rs_neg_c    = is_signed_c && rs_val[W-1];
        rt_neg_c    = is_signed_c && rt_val[W-1];
        rs_mag_c    = rs_neg_c ? W'(-rs_val) : rs_val;
        rt_mag_c    = rt_neg_c ? W'(-rt_val) : rt_val;
    end

    // One iteration of either datapath, and the sign-fixed final result
    always_comb begin
        mul_sum   = (W+1)'(acc_q[2*W-1:W]) + (acc_q[0] ? (W+1)'(mcand_q) : (W+1)'(0));
        div_trial = {rem_q, acc_q[W-1]};
        div_ge    = div_trial >= (W+2)'(mcand_q);
        rem_d     = div_ge ? (W+1)'(div_trial - (W+2)'(mcand_q)) : div_trial[W:0];
        acc_d     = is_div_q ? {acc_q[2*W-1:W], acc_q[W-2:0], div_ge}
                             : {mul_sum, acc_q[W-1:1]};
        prod      = neg_q ? (2*W)'(-acc_d) : acc_d;
        quot      = neg_q ? W'(-acc_d[W-1:0]) : acc_d[W-1:0];
        remf      = neg_rem_q ? W'(-rem_d[W-1:0]) : rem_d[W-1:0];
        res_hi    = prod[2*W-1:W];
        res_lo    = prod[W-1:0];
        if (is_div_q) begin
            res_hi = dz_q ? rs_q : remf;
            res_lo = dz_q ? {W{1'b1}} : quot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            rs_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && is_md_c) begin
                        state_q   <= S_RUN;
                        cnt_q     <= '0;
                        is_div_q  <= is_div_c;
                        neg_q     <= rs_neg_c ^ rt_neg_c;
                        neg_rem_q <= rs_neg_c && is_div_c;
                        dz_q      <= (rt_val == '0);
                        rs_q      <= rs_val;
                        rem_q     <= '0;
                        // Divide shifts the dividend out of acc; multiply shifts the multiplier
                        acc_q     <= {{W{1'b0}}, (is_div_c ? rs_mag_c : rt_mag_c)};
                        mcand_q   <= is_div_c ? rt_mag_c : rs_mag_c;
                    end else if (start && op == OP_MTHI) begin
                        hi_q <= rs_val;
                    end else if (start && op == OP_MTLO) begin
                        lo_q <= rs_val;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall = ((state_q == S_IDLE) && start && is_md_c) || (state_q == S_RUN);
    assign busy  = (state_q == S_RUN);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized scoreboard bench for mdu_hilo: expected HI/LO queued at issue,
// popped and compared by a monitor when busy falls.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic prev_busy = 1'b0;

    mdu_hilo dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .stall  (stall),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // Architectural result {hi, lo} computed with plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int q;
        int r;
        logic [31:0] uq;
        logic [31:0] ur;
        case (o)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 64'(p);
            end
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a completed mul/div shows up as busy falling
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (prev_busy && !busy && !rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("result", {hi, lo}, e);
        end
        prev_busy <= busy;
    end

    // Drive a mul/div now, scramble operands mid-run, count stalled cycles up to DONE
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int cnt = 0;
        bit done = 0;
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        exp_q.push_back(ref_model(o, a, b));
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stall) cnt++;
            else done = 1;
            if (i == 2) begin
                rs_val = $urandom;
                rt_val = $urandom;
            end
        end
        chk("stall_cycles", 64'(cnt), 64'd33);
        chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        run_op(o, a, b);
    endtask

    task automatic drop_start();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_stall", {62'd0, busy, stall}, 64'd0);

        // Directed: back-to-back issues hold start straight through DONE
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        // New MULT presented during DONE must wait for IDLE
        run_op(3'd1, 32'h0000_1234, 32'hFFFF_0000);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd4, 32'h1234_5678, 32'd0);
        issue(3'd3, 32'hFFFF_FF00, 32'd0);
        drop_start();

        // MTHI then MTLO on consecutive cycles
        @(posedge clk); #1;
        op = 3'd5; rs_val = 32'hAAAA_0000; start = 1'b1;
        @(negedge clk);
        chk("mthi_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op = 3'd6; rs_val = 32'h0000_BBBB;
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'hAAAA_0000);
        chk("mtlo_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op = 3'd7; rs_val = 32'h5555_5555;
        @(negedge clk);
        chk("mtlo_hilo", {hi, lo}, 64'hAAAA_0000_0000_BBBB);
        chk("noop_stall_busy", {62'd0, busy, stall}, 64'd0);
        @(posedge clk); #1;
        op = 3'd0;
        @(negedge clk);
        chk("noop_hilo", {hi, lo}, 64'hAAAA_0000_0000_BBBB);
        drop_start();

        // Reset in the middle of a MULTU discards it
        @(posedge clk); #1;
        op = 3'd2; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
        repeat (11) @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        chk("midrun_reset_hilo", {hi, lo}, 64'd0);
        chk("midrun_reset_busy_stall", {62'd0, busy, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'd2, 32'd5, 32'd5);
        drop_start();

        // Random mix, including zero and small divisors and sign extremes
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 17));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(ro, ra, rb);
            if ($urandom_range(0, 1) == 1) drop_start();
        end
        drop_start();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
